// File: rtl/trbpkt_rd_fetch_if.sv
// Read-request, read-response and converter-side line bus of the turbo-packet fetcher.
// The master (fetcher) drives requests and lines; the slave side is host memory plus the converter.
interface trbpkt_rd_fetch_if #(
    parameter int BUS    = 534,
    parameter int LINE   = 512,
    parameter int TAG_W  = 5,
    parameter int ADDR_W = 42
) ();
    logic              rd_req_valid;
    logic [ADDR_W-1:0] rd_req_addr;
    logic [TAG_W-1:0]  rd_req_tag;
    logic              rd_req_almfull;
    logic              rd_rsp_valid;
    logic [TAG_W-1:0]  rd_rsp_tag;
    logic [LINE-1:0]   rd_rsp_data;
    logic [BUS-1:0]    bus_data;
    logic              bus_en;
    logic              bus_ready;

    modport master (
        output rd_req_valid, rd_req_addr, rd_req_tag,
        input  rd_req_almfull,
        input  rd_rsp_valid, rd_rsp_tag, rd_rsp_data,
        output bus_data, bus_en,
        input  bus_ready
    );

    modport slave (
        input  rd_req_valid, rd_req_addr, rd_req_tag,
        output rd_req_almfull,
        output rd_rsp_valid, rd_rsp_tag, rd_rsp_data,
        input  bus_data, bus_en,
        output bus_ready
    );
endinterface

// File: rtl/trbpkt_rd_fetch.sv
// Turbo-packet fetcher: reads lines per packet, reorders responses, forwards in order (start->req 1 cycle, rsp->bus_en >=2 cycles);
// stalls on rd_req_almfull / bus_ready / converter completion. Define TRB_FETCH_RSP_CHK_EN to flag bad response tags into err.
module trbpkt_rd_fetch #(
    parameter int BUS                   = 534,
    parameter int LINE                  = 512,
    parameter int NUM_BUS_PER_TURBO_PKT = 25,
    parameter int TAG_W                 = 5,
    parameter int ADDR_W                = 42
) (
    input  logic              clk_bus,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [15:0]       i_num_pkts,
    input  logic              i_mem_rd_complt_clk_bus,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    trbpkt_rd_fetch_if.master bus_if
);
    localparam int               N        = NUM_BUS_PER_TURBO_PKT;
    localparam logic [TAG_W:0]   N_ISS    = (TAG_W+1)'(N);
    localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(N-1);
    localparam logic [ADDR_W-1:0] PKT_STRIDE = ADDR_W'(N);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FLUSH} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pkt_addr;
    logic [15:0]       r_num_pkts;
    logic [15:0]       r_pkt_idx;
    logic [15:0]       r_cmplt_cnt;
    logic              r_cmplt_prev;
    logic [TAG_W:0]    r_issued;
    logic [TAG_W-1:0]  r_fwd_idx;
    logic              r_fwd_open;
    logic [N-1:0]      r_valid;
    logic [LINE-1:0]   r_mem [N];
    logic              r_rd_req_valid;
    logic [ADDR_W-1:0] r_rd_req_addr;
    logic [TAG_W-1:0]  r_rd_req_tag;
    logic              r_bus_en;
    logic [LINE-1:0]   r_bus_data;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic                 w_cmplt_edge;
    logic [2**TAG_W-1:0]  w_valid_pad;
    logic                 w_rsp_in_range;
    logic                 w_rsp_hit;
    logic                 w_rsp_wr;
    logic                 w_rsp_bad;
    logic                 w_send;
    logic                 w_last;
    logic                 w_can_req;

    always_comb begin
        w_cmplt_edge       = i_mem_rd_complt_clk_bus && !r_cmplt_prev;
        w_valid_pad        = '0;
        w_valid_pad[N-1:0] = r_valid;
        w_rsp_in_range     = bus_if.rd_rsp_tag <= LAST_TAG;
        w_rsp_hit          = bus_if.rd_rsp_valid && (r_state != S_IDLE);
`ifdef TRB_FETCH_RSP_CHK_EN
        w_rsp_wr  = w_rsp_hit && w_rsp_in_range && !w_valid_pad[bus_if.rd_rsp_tag];
        w_rsp_bad = w_rsp_hit && (!w_rsp_in_range || w_valid_pad[bus_if.rd_rsp_tag]);
`else
        w_rsp_wr  = w_rsp_hit && w_rsp_in_range;
        w_rsp_bad = 1'b0;
`endif
        w_send    = (r_state == S_FETCH) && r_fwd_open && r_valid[r_fwd_idx] && bus_if.bus_ready;
        w_last    = r_fwd_idx == LAST_TAG;
        w_can_req = (r_state == S_FETCH) && (r_issued < N_ISS) && !bus_if.rd_req_almfull;
    end

    always_ff @(posedge clk_bus) begin
        if (w_rsp_wr) r_mem[bus_if.rd_rsp_tag] <= bus_if.rd_rsp_data;
    end

    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_pkt_addr     <= '0;
            r_num_pkts     <= '0;
            r_pkt_idx      <= '0;
            r_cmplt_cnt    <= '0;
            r_cmplt_prev   <= 1'b0;
            r_issued       <= '0;
            r_fwd_idx      <= '0;
            r_fwd_open     <= 1'b0;
            r_valid        <= '0;
            r_rd_req_valid <= 1'b0;
            r_rd_req_addr  <= '0;
            r_rd_req_tag   <= '0;
            r_bus_en       <= 1'b0;
            r_bus_data     <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_cmplt_prev   <= i_mem_rd_complt_clk_bus;
            r_rd_req_valid <= 1'b0;
            r_bus_en       <= 1'b0;
            r_done         <= 1'b0;

            if (w_rsp_wr) r_valid[bus_if.rd_rsp_tag] <= 1'b1;
            if (w_rsp_bad) r_err <= 1'b1;
            if (w_cmplt_edge && r_state != S_IDLE) r_cmplt_cnt <= r_cmplt_cnt + 16'd1;

            if (w_can_req) begin
                r_rd_req_valid <= 1'b1;
                r_rd_req_addr  <= r_pkt_addr + ADDR_W'(r_issued);
                r_rd_req_tag   <= r_issued[TAG_W-1:0];
                r_issued       <= r_issued + 1'b1;
            end

            if (w_send) begin
                r_bus_en           <= 1'b1;
                r_bus_data         <= r_mem[r_fwd_idx];
                r_valid[r_fwd_idx] <= 1'b0;
                r_fwd_idx          <= r_fwd_idx + 1'b1;
                if (w_last) begin
                    r_fwd_open <= 1'b0;
                    r_issued   <= '0;
                    r_fwd_idx  <= '0;
                    if (r_pkt_idx + 16'd1 < r_num_pkts) begin
                        r_pkt_idx  <= r_pkt_idx + 16'd1;
                        r_pkt_addr <= r_pkt_addr + PKT_STRIDE;
                    end else begin
                        r_state <= S_FLUSH;
                    end
                end
            end

            // Placed after the packet-end clear so a coincident completion edge reopens forwarding.
            if (w_cmplt_edge && r_state == S_FETCH) r_fwd_open <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (i_start && !r_busy) begin
                        r_busy      <= 1'b1;
                        r_num_pkts  <= i_num_pkts;
                        r_pkt_addr  <= i_base_addr;
                        r_pkt_idx   <= '0;
                        r_cmplt_cnt <= '0;
                        r_fwd_open  <= 1'b1;
                        r_fwd_idx   <= '0;
                        r_issued    <= '0;
                        if (i_num_pkts == 16'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                            // First request goes out straight from IDLE to meet the one-cycle start latency.
                            if (!bus_if.rd_req_almfull) begin
                                r_rd_req_valid <= 1'b1;
                                r_rd_req_addr  <= i_base_addr;
                                r_rd_req_tag   <= '0;
                                r_issued       <= (TAG_W+1)'(1);
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    if (r_cmplt_cnt == r_num_pkts) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_if.rd_req_valid = r_rd_req_valid;
    assign bus_if.rd_req_addr  = r_rd_req_addr;
    assign bus_if.rd_req_tag   = r_rd_req_tag;
    assign bus_if.bus_en       = r_bus_en;
    assign bus_if.bus_data     = {r_bus_data, {(BUS-LINE){1'b0}}};
    assign o_busy              = r_busy;
    assign o_done              = r_done;
    assign o_err               = r_err;
endmodule
